// File: rtl/nonogram_solver.sv
// nonogram_solver: line-elimination core of the nonogram solver.
// Filters each line's option stream against the board and commits agreed cells.
module nonogram_solver #(
  parameter int MAX_ROWS = 3,
  parameter int MAX_COLS = 3,
  localparam int W  = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
  localparam int L  = MAX_ROWS + MAX_COLS,
  localparam int RW = $clog2(MAX_ROWS + 1),
  localparam int CW = $clog2(MAX_COLS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               started,
  input  logic [W-1:0]                       option,
  input  logic [RW-1:0]                      num_rows,
  input  logic [CW-1:0]                      num_cols,
  input  logic [L-1:0][6:0]                  old_options_amnt,
  output logic                               new_line,
  output logic                               put_back_to_FIFO,
  output logic [MAX_ROWS-1:0][MAX_COLS-1:0]  assigned,
  output logic [MAX_ROWS-1:0][MAX_COLS-1:0]  known,
  output logic                               solved
);

  localparam int LW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, INDEX, OPTION} state_t;

  typedef logic [MAX_ROWS-1:0][MAX_COLS-1:0] grid_t;

  state_t             state, state_nx;
  logic               first;
  logic [L-1:0][6:0]  cnt;
  logic [W-1:0]       line_n;
  logic [6:0]         line_c;
  logic [6:0]         opt_cnt;
  logic [W-1:0]       and_m, or_m;
  logic [6:0]         surv;

  logic               idx_ok;
  logic [LW-1:0]      idx;
  logic [6:0]         c_in;
  logic               is_row;
  grid_t              on_line, pat, am_cell, om_cell;
  grid_t              and_cell, or_cell, set1, set0;
  logic               consistent, last, all_known;
  logic [W-1:0]       and_nx, or_nx;
  logic [6:0]         surv_nx;

  always_comb begin
    idx_ok = int'(option) < (int'(num_rows) + int'(num_cols));
    idx    = idx_ok ? LW'(option) : '0;
    c_in   = '0;
    if (idx_ok)
      c_in = first ? old_options_amnt[idx] : cnt[idx];
  end

  // Map every board cell onto the current line's pattern position.
  always_comb begin
    is_row  = int'(line_n) < int'(num_rows);
    on_line = '0;
    pat     = '0;
    am_cell = '0;
    om_cell = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      for (int c = 0; c < MAX_COLS; c++) begin
        if (is_row && r == int'(line_n) && c < int'(num_cols)) begin
          on_line[r][c] = 1'b1;
          pat[r][c]     = option[W-1-c];
          am_cell[r][c] = and_m[W-1-c];
          om_cell[r][c] = or_m[W-1-c];
        end else if (!is_row && r < int'(num_rows) &&
                     c == int'(line_n) - int'(num_rows)) begin
          on_line[r][c] = 1'b1;
          pat[r][c]     = option[W-1-r];
          am_cell[r][c] = and_m[W-1-r];
          om_cell[r][c] = or_m[W-1-r];
        end
      end
    end
    consistent = ~|(on_line & known & (assigned ^ pat));
  end

  always_comb begin
    and_cell = consistent ? (am_cell & pat) : am_cell;
    or_cell  = consistent ? (om_cell | pat) : om_cell;
    and_nx   = consistent ? (and_m & option) : and_m;
    or_nx    = consistent ? (or_m | option) : or_m;
    surv_nx  = surv + {6'd0, consistent};
    last     = (opt_cnt == line_c - 7'd1);
    set1     = on_line & ~known & and_cell;
    set0     = on_line & ~known & ~or_cell;
    all_known = 1'b1;
    for (int r = 0; r < MAX_ROWS; r++)
      for (int c = 0; c < MAX_COLS; c++)
        if (r < int'(num_rows) && c < int'(num_cols) && !known[r][c])
          all_known = 1'b0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      INDEX:   if (idx_ok && c_in != '0) state_nx = OPTION;
      OPTION:  if (last) state_nx = INDEX;
      default: state_nx = IDLE;
    endcase
    if (started)
      state_nx = INDEX;
    new_line         = (state == INDEX);
    put_back_to_FIFO = (state == OPTION) && consistent && (line_c > 7'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b0;
      cnt      <= '0;
      line_n   <= '0;
      line_c   <= '0;
      opt_cnt  <= '0;
      and_m    <= '0;
      or_m     <= '0;
      surv     <= '0;
      known    <= '0;
      assigned <= '0;
      solved   <= 1'b0;
    end else if (started) begin
      known    <= '0;
      assigned <= '0;
      solved   <= 1'b0;
      first    <= 1'b1;
    end else begin
      solved <= solved | all_known;
      if (state == INDEX) begin
        if (first) begin
          cnt   <= old_options_amnt;
          first <= 1'b0;
        end
        if (idx_ok && c_in != '0) begin
          line_n  <= option;
          line_c  <= c_in;
          opt_cnt <= '0;
          and_m   <= '1;
          or_m    <= '0;
          surv    <= '0;
        end
      end
      if (state == OPTION) begin
        and_m   <= and_nx;
        or_m    <= or_nx;
        surv    <= surv_nx;
        opt_cnt <= opt_cnt + 7'd1;
        if (last) begin
          // A line with no survivors is dropped without touching the board.
          if (surv_nx != '0) begin
            known    <= known | set1 | set0;
            assigned <= (assigned & ~set0) | set1;
          end
          cnt[LW'(line_n)] <= surv_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_nonogram_solver.sv
// tb_nonogram_solver: scoreboard bench for nonogram_solver.
// A behavioural line model predicts outputs for each driven word.
module tb_nonogram_solver;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             started = 1'b0;
  logic [2:0]       option = '0;
  logic [1:0]       num_rows = 2'd3;
  logic [1:0]       num_cols = 2'd3;
  logic [5:0][6:0]  old_options_amnt = '0;
  logic             new_line, put_back_to_FIFO, solved;
  logic [2:0][2:0]  assigned, known;

  nonogram_solver #(.MAX_ROWS(3), .MAX_COLS(3)) dut (
    .clk(clk), .rst(rst), .started(started), .option(option),
    .num_rows(num_rows), .num_cols(num_cols),
    .old_options_amnt(old_options_amnt),
    .new_line(new_line), .put_back_to_FIFO(put_back_to_FIFO),
    .assigned(assigned), .known(known), .solved(solved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nl;
    logic       pb;
    logic [8:0] kn;
    logic [8:0] as;
    logic       so;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  int NR = 3, NC = 3;
  int oldc[6];
  int m_st, m_n, m_c, m_k, m_surv;
  bit m_first, m_sol;
  int m_cnt[6];
  bit m_and[3], m_or[3];
  bit mk[3][3], ma[3][3];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int llen(int n);
    return (n < NR) ? NC : NR;
  endfunction

  function automatic int cell_r(int n, int i);
    return (n < NR) ? n : i;
  endfunction

  function automatic int cell_c(int n, int i);
    return (n < NR) ? i : n - NR;
  endfunction

  function automatic bit m_consistent(logic [2:0] w);
    for (int i = 0; i < llen(m_n); i++) begin
      int r = cell_r(m_n, i);
      int c = cell_c(m_n, i);
      if (mk[r][c] && ma[r][c] != w[2-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_first = 0; m_sol = 0;
    m_n = 0; m_c = 0; m_k = 0; m_surv = 0;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        mk[r][c] = 0; ma[r][c] = 0;
      end
  endtask

  task automatic model_edge(input logic [2:0] w, input logic st);
    bit allk, ok;
    int n, c;
    if (st) begin
      for (int r = 0; r < 3; r++)
        for (int q = 0; q < 3; q++) begin
          mk[r][q] = 0; ma[r][q] = 0;
        end
      m_sol = 0; m_first = 1; m_st = 1;
      return;
    end
    allk = 1;
    for (int r = 0; r < NR; r++)
      for (int q = 0; q < NC; q++)
        if (!mk[r][q]) allk = 0;
    m_sol = m_sol | allk;
    if (m_st == 1) begin
      n = int'(w);
      c = 0;
      if (n < NR + NC) c = m_first ? oldc[n] : m_cnt[n];
      if (m_first) begin
        m_cnt = oldc;
        m_first = 0;
      end
      if (c != 0) begin
        m_n = n; m_c = c; m_k = 0; m_surv = 0;
        for (int i = 0; i < 3; i++) begin
          m_and[i] = 1; m_or[i] = 0;
        end
        m_st = 2;
      end
    end else if (m_st == 2) begin
      ok = m_consistent(w);
      if (ok) begin
        for (int i = 0; i < 3; i++) begin
          m_and[i] = m_and[i] & w[2-i];
          m_or[i]  = m_or[i] | w[2-i];
        end
        m_surv++;
      end
      m_k++;
      if (m_k == m_c) begin
        if (m_surv > 0)
          for (int i = 0; i < llen(m_n); i++) begin
            int r = cell_r(m_n, i);
            int q = cell_c(m_n, i);
            if (!mk[r][q]) begin
              if (m_and[i]) begin
                mk[r][q] = 1; ma[r][q] = 1;
              end else if (!m_or[i]) begin
                mk[r][q] = 1; ma[r][q] = 0;
              end
            end
          end
        m_cnt[m_n] = m_surv;
        m_st = 1;
      end
    end
  endtask

  task automatic apply_cfg();
    num_rows = 2'(NR);
    num_cols = 2'(NC);
    for (int i = 0; i < 6; i++) old_options_amnt[i] = 7'(oldc[i]);
  endtask

  task automatic step(input logic [2:0] w, input logic st);
    exp_t e;
    @(negedge clk);
    option  = w;
    started = st;
    e.nl = (m_st == 1);
    e.pb = (m_st == 2) && m_consistent(w) && (m_c > 1);
    model_edge(w, st);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        e.kn[r*3+c] = mk[r][c];
        e.as[r*3+c] = ma[r][c];
      end
    e.so = m_sol;
    sb.push_back(e);
    #1;
    chk("new_line", new_line, sb[0].nl);
    chk("put_back", put_back_to_FIFO, sb[0].pb);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("known", known, e.kn);
    chk("assigned", assigned, e.as);
    chk("solved", solved, e.so);
    started = 1'b0;
  endtask

  initial begin
    oldc = '{2, 3, 1, 1, 2, 3};
    apply_cfg();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_new_line", new_line, 1'b0);
    chk("rst_put_back", put_back_to_FIFO, 1'b0);
    chk("rst_known", known, 9'd0);
    chk("rst_assigned", assigned, 9'd0);
    chk("rst_solved", solved, 1'b0);
    rst = 1'b0;
    step(3'd0, 1'b0);
    step(3'd0, 1'b1);
    // Directed solve of the 3x3 example board.
    step(3'd0, 0); step(3'b110, 0); step(3'b011, 0);
    step(3'd2, 0); step(3'b101, 0);
    step(3'd4, 0); step(3'b110, 0); step(3'b011, 0);
    step(3'd3, 0); step(3'b101, 0);
    step(3'd1, 0); step(3'b100, 0); step(3'b010, 0); step(3'b001, 0);
    step(3'd5, 0); step(3'b100, 0); step(3'b010, 0); step(3'b001, 0);
    step(3'd6, 0);
    chk("solved_final", solved, 1'b1);
    // Second pass: surviving counts, out-of-range indices.
    step(3'd2, 0); step(3'b101, 0);
    step(3'd6, 0); step(3'd7, 0);
    step(3'd4, 0); step(3'b110, 0);
    // Reset in the middle of a line.
    step(3'd0, 1); step(3'd0, 0); step(3'b110, 0);
    @(negedge clk);
    option = 3'b011;
    #2 rst = 1'b1;
    #1;
    chk("arst_new_line", new_line, 1'b0);
    chk("arst_put_back", put_back_to_FIFO, 1'b0);
    chk("arst_known", known, 9'd0);
    chk("arst_solved", solved, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(3'd0, 0); step(3'd1, 0);
    // Restart on a partially known board with new counts.
    step(3'd0, 1); step(3'd2, 0); step(3'b101, 0);
    oldc = '{1, 3, 1, 2, 2, 3};
    apply_cfg();
    step(3'd0, 1); step(3'd0, 0); step(3'b110, 0); step(3'b011, 0);
    step(3'd3, 0); step(3'b101, 0);
    // Randomised streams on varied board sizes.
    for (int run = 0; run < 4; run++) begin
      NR = $urandom_range(1, 3);
      NC = $urandom_range(1, 3);
      for (int i = 0; i < 6; i++) oldc[i] = $urandom_range(0, 3);
      apply_cfg();
      step(3'($urandom_range(0, 7)), 1);
      for (int k = 0; k < 150; k++)
        step(3'($urandom_range(0, 7)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
